// File: rtl/sequence_stimulus_driver.sv
// sequence_stimulus_driver: steps a 4-bit sequence index with a step clock for an evaluation run, then holds the result.
// Optional looping over LOOPS passes is compiled in with SEQUENCE_DRIVER_LOOP_EN.
module sequence_stimulus_driver #(
    parameter int CYCLES_PER_STEP = 64,
    parameter int LOOPS = 2
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iStart,
    input  logic [4:0] iSequenceLength,
    input  logic       iAck,
    output logic       oProcessing,
    output logic       oKeepResult,
    output logic       oClockLevel,
    output logic [3:0] oCurrentSequence,
    output logic       oBusy,
    output logic       oDone
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [4:0]  len_q;
    logic [4:0]  len_d;
    logic        proc_q, keep_q, clk_q, busy_q, done_q;
    logic [3:0]  seq_q;
    logic        step_end, seq_end, last_pass;

    assign len_d    = (iSequenceLength == 5'd0 || iSequenceLength > 5'd16) ? 5'd16 : iSequenceLength;
    assign cnt_d    = cnt_q + 16'd1;
    assign step_end = cnt_q == 16'(CYCLES_PER_STEP - 1);
    assign seq_end  = {1'b0, seq_q} == len_q - 5'd1;

`ifdef SEQUENCE_DRIVER_LOOP_EN
    logic [7:0] pass_q;
    assign last_pass = pass_q == 8'(LOOPS - 1);
`else
    assign last_pass = 1'b1;
`endif

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            proc_q  <= 1'b0;
            keep_q  <= 1'b0;
            clk_q   <= 1'b0;
            seq_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQUENCE_DRIVER_LOOP_EN
            pass_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (iStart) begin
                    state_q <= RUN;
                    len_q   <= len_d;
                    cnt_q   <= '0;
                    proc_q  <= 1'b1;
                    keep_q  <= 1'b0;
                    clk_q   <= 1'b1;
                    seq_q   <= '0;
                    busy_q  <= 1'b1;
`ifdef SEQUENCE_DRIVER_LOOP_EN
                    pass_q  <= '0;
`endif
                end
                RUN: if (!step_end) begin
                    cnt_q <= cnt_d;
                end else if (seq_end && last_pass) begin
                    // step clock and index stay frozen for the consumer
                    state_q <= HOLD;
                    cnt_q   <= '0;
                    proc_q  <= 1'b0;
                    keep_q  <= 1'b1;
                    done_q  <= 1'b1;
                end else begin
                    cnt_q <= '0;
                    clk_q <= ~clk_q;
                    seq_q <= seq_end ? 4'd0 : seq_q + 4'd1;
`ifdef SEQUENCE_DRIVER_LOOP_EN
                    if (seq_end) pass_q <= pass_q + 8'd1;
`endif
                end
                HOLD: begin
                    done_q <= 1'b0;
                    if (iAck) begin
                        state_q <= IDLE;
                        keep_q  <= 1'b0;
                        clk_q   <= 1'b0;
                        seq_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oProcessing      = proc_q;
    assign oKeepResult      = keep_q;
    assign oClockLevel      = clk_q;
    assign oCurrentSequence = seq_q;
    assign oBusy            = busy_q;
    assign oDone            = done_q;
endmodule

// File: tb/tb_sequence_stimulus_driver.sv
// tb_sequence_stimulus_driver: two instances (4 and 2 cycles per step) checked cycle by cycle against a step/pass model.
module tb_sequence_stimulus_driver;
    localparam int LP = 2;
`ifdef SEQUENCE_DRIVER_LOOP_EN
    localparam int PASSES = LP;
`else
    localparam int PASSES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, ack;
    logic [4:0] len;
    logic [1:0] proc, keep, clkl, busy, done;
    logic [3:0] seq [2];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sequence_stimulus_driver #(.CYCLES_PER_STEP(4), .LOOPS(LP)) d4 (
        .iClock(clk), .iReset(rst), .iStart(start[0]), .iSequenceLength(len), .iAck(ack[0]),
        .oProcessing(proc[0]), .oKeepResult(keep[0]), .oClockLevel(clkl[0]),
        .oCurrentSequence(seq[0]), .oBusy(busy[0]), .oDone(done[0]));

    sequence_stimulus_driver #(.CYCLES_PER_STEP(2), .LOOPS(LP)) d2 (
        .iClock(clk), .iReset(rst), .iStart(start[1]), .iSequenceLength(len), .iAck(ack[1]),
        .oProcessing(proc[1]), .oKeepResult(keep[1]), .oClockLevel(clkl[1]),
        .oCurrentSequence(seq[1]), .oBusy(busy[1]), .oDone(done[1]));

    function automatic int cps(int sel);
        return sel ? 2 : 4;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(int sel, logic p, logic k, logic c, logic [3:0] s, logic b, logic d);
        chk($sformatf("u%0d proc", sel), 32'(proc[sel]), 32'(p));
        chk($sformatf("u%0d keep", sel), 32'(keep[sel]), 32'(k));
        chk($sformatf("u%0d clk", sel), 32'(clkl[sel]), 32'(c));
        chk($sformatf("u%0d seq", sel), 32'(seq[sel]), 32'(s));
        chk($sformatf("u%0d busy", sel), 32'(busy[sel]), 32'(b));
        chk($sformatf("u%0d done", sel), 32'(done[sel]), 32'(d));
    endtask

    task automatic run(int sel, logic [4:0] l, int rst_at, int hold_n);
        int n, t, g;
        n = (l == 5'd0 || l > 5'd16) ? 16 : int'(l);
        t = n * cps(sel) * PASSES;
        len = l;
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        len = 5'($urandom);
        for (int k = 0; k < t + hold_n; k++) begin
            g = (k < t ? k : t - 1) / cps(sel);
            if (k < t) chk_all(sel, 1'b1, 1'b0, g % 2 == 0, 4'(g % n), 1'b1, 1'b0);
            else chk_all(sel, 1'b0, 1'b1, g % 2 == 0, 4'(g % n), 1'b1, k == t);
            if (k == rst_at) begin
                rst = 1'b1;
                start = '0;
                ack = '0;
                @(negedge clk);
                rst = 1'b0;
                chk_all(sel, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
                return;
            end
            start[sel] = $urandom_range(7) == 0;
            ack[sel] = (k < t) && ($urandom_range(1) == 1);
            @(negedge clk);
        end
        start[sel] = 1'b0;
        ack[sel] = 1'b1;
        @(negedge clk);
        ack[sel] = 1'b0;
        chk_all(sel, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = '0;
        ack = '0;
        len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk_all(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        ack = 2'b11;
        @(negedge clk);
        ack = '0;
        chk_all(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        run(0, 5'd3, -1, 5);
        run(1, 5'd0, -1, 50);
        run(0, 5'd3, 7, 0);
        run(1, 5'd2, -1, 2);
        run(1, 5'd20, -1, 1);
        run(1, 5'd1, 2 * PASSES + 1, 4);
        repeat (8) run(int'($urandom_range(1)), 5'($urandom), -1, int'($urandom_range(1, 5)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
